// File: rtl/ad_ip_jesd204_tpl_adc_frame_align.sv
// TPL ADC link-side frame aligner: detects the frame-start octet
// from link_sof and rotates every lane so frames start at octet 0.
module ad_ip_jesd204_tpl_adc_frame_align #(
  parameter int NUM_LANES       = 1,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int BYTES_PER_FRAME = 2,
  parameter int MISALIGN_THRESH = 4,
  localparam int DW = NUM_LANES * 8 * OCTETS_PER_BEAT,
  localparam int OW = (OCTETS_PER_BEAT > 1) ?
                      $clog2(OCTETS_PER_BEAT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       link_valid,
  input  logic [OCTETS_PER_BEAT-1:0] link_sof,
  input  logic [DW-1:0]              link_data,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic                       aligned,
  output logic [OW-1:0]              offset,
  output logic [7:0]                 realign_count
);

  localparam int OPB = OCTETS_PER_BEAT;
  localparam int F   = BYTES_PER_FRAME;

  if ((OPB % F) != 0) begin : g_bad_f
    $error("BYTES_PER_FRAME must divide OCTETS_PER_BEAT");
  end
  if (OPB != 4 && OPB != 8) begin : g_bad_opb
    $error("OCTETS_PER_BEAT must be 4 or 8");
  end
  if (MISALIGN_THRESH < 1 || MISALIGN_THRESH > 255) begin : g_bad_th
    $error("MISALIGN_THRESH must be 1..255");
  end

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_d;
  logic [7:0]    cnt, cnt_d;
  logic [7:0]    rc_d;
  logic [OW-1:0] k_d;
  logic          ov_d;
  logic [DW-1:0] prev;
  logic [DW-1:0] shifted;
  logic          pat_ok;
  logic [OW-1:0] p;
  logic          match;
  logic          mis_hit;

  // Decode the SOF pattern: one-hot in the first frame, periodic by F.
  always_comb begin
    pat_ok = $onehot(link_sof[F-1:0]);
    p      = '0;
    for (int i = 0; i < F; i++) begin
      if (link_sof[i]) p = OW'(i);
    end
    for (int i = F; i < OPB; i++) begin
      if (link_sof[i] != link_sof[i-F]) pat_ok = 1'b0;
    end
  end

  assign match   = pat_ok && (p == offset);
  assign mis_hit = (state == LOCKED) && link_valid && !match &&
                   (cnt == 8'(MISALIGN_THRESH - 1));

  // Window of prev|cur per lane, picking octets k..k+OPB-1.
  always_comb begin
    shifted = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int o = 0; o < OPB; o++) begin
        if (int'(offset) + o < OPB)
          shifted[(l*OPB+o)*8 +: 8] =
            prev[(l*OPB+int'(offset)+o)*8 +: 8];
        else
          shifted[(l*OPB+o)*8 +: 8] =
            link_data[(l*OPB+int'(offset)+o-OPB)*8 +: 8];
      end
    end
  end

  // Registers: state, counters, offset, previous beat, output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SEARCH;
      cnt           <= '0;
      offset        <= '0;
      realign_count <= '0;
      prev          <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      offset        <= k_d;
      realign_count <= rc_d;
      out_valid     <= ov_d;
      if (link_valid) prev <= link_data;
      if (ov_d) out_data <= shifted;
    end
  end

  // Next state: lock on a good pattern, drop after too many misses.
  always_comb begin
    state_d = state;
    unique case (state)
      SEARCH: if (link_valid && pat_ok) state_d = LOCKED;
      LOCKED: if (mis_hit) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Next values of offset, miss counter, relock count and out_valid.
  always_comb begin
    cnt_d = cnt;
    k_d   = offset;
    rc_d  = realign_count;
    ov_d  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (link_valid && pat_ok) begin
          k_d   = p;
          cnt_d = '0;
        end
      end
      LOCKED: begin
        ov_d = link_valid;
        if (link_valid) begin
          if (match) begin
            cnt_d = '0;
          end else if (mis_hit) begin
            cnt_d = '0;
            if (realign_count != 8'hFF)
              rc_d = realign_count + 8'd1;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign aligned = (state == LOCKED);

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_frame_align.sv
// Directed bench for the TPL ADC frame aligner: narrow 1-lane
// instance plus a 4-lane, 8-octet, F=4 instance.
module tb_ad_ip_jesd204_tpl_adc_frame_align;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        v_a;
  logic [3:0]  sof_a;
  logic [31:0] d_a;
  logic        ov_a;
  logic [31:0] od_a;
  logic        al_a;
  logic [1:0]  off_a;
  logic [7:0]  rc_a;

  logic         v_b;
  logic [7:0]   sof_b;
  logic [255:0] d_b;
  logic         ov_b;
  logic [255:0] od_b;
  logic         al_b;
  logic [2:0]   off_b;
  logic [7:0]   rc_b;

  ad_ip_jesd204_tpl_adc_frame_align #(
    .NUM_LANES(1), .OCTETS_PER_BEAT(4),
    .BYTES_PER_FRAME(2), .MISALIGN_THRESH(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .link_valid(v_a), .link_sof(sof_a), .link_data(d_a),
    .out_valid(ov_a), .out_data(od_a), .aligned(al_a),
    .offset(off_a), .realign_count(rc_a)
  );

  ad_ip_jesd204_tpl_adc_frame_align #(
    .NUM_LANES(4), .OCTETS_PER_BEAT(8),
    .BYTES_PER_FRAME(4), .MISALIGN_THRESH(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .link_valid(v_b), .link_sof(sof_b), .link_data(d_b),
    .out_valid(ov_b), .out_data(od_b), .aligned(al_b),
    .offset(off_b), .realign_count(rc_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v_a = 1'b0; sof_a = '0; d_a = '0;
    v_b = 1'b0; sof_b = '0; d_b = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic beat(input logic [3:0] s, input logic [31:0] d);
    v_a = 1'b1; sof_a = s; d_a = d;
    tick();
  endtask

  task automatic gap(input logic [3:0] s, input logic [31:0] d);
    v_a = 1'b0; sof_a = s; d_a = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v_a = 1'b1; sof_a = 4'b0101; d_a = $urandom;
    v_b = 1'b1; sof_b = 8'h11;
    d_b = {8{$urandom}};
    tick();
    d_a = $urandom;
    tick();
    checks++;
    if (ov_a !== 1'b0 || od_a !== 32'h0 || al_a !== 1'b0 ||
        off_a !== 2'd0 || rc_a !== 8'd0) begin
      failures++;
      $display("FAIL reset_a ov=%b od=%h al=%b off=%0d rc=%0d exp 0",
               ov_a, od_a, al_a, off_a, rc_a);
    end
    checks++;
    if (ov_b !== 1'b0 || od_b !== '0 || al_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b ov=%b al=%b exp 0", ov_b, al_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_k0();
    do_reset();
    beat(4'b0101, 32'h03020100);
    checks++;
    if (al_a !== 1'b1 || off_a !== 2'd0 || ov_a !== 1'b0) begin
      failures++;
      $display("FAIL lock_k0 al=%b off=%0d ov=%b exp 1 0 0",
               al_a, off_a, ov_a);
    end
    beat(4'b0101, 32'h07060504);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'h03020100) begin
      failures++;
      $display("FAIL data_k0 ov=%b od=%h exp 1 03020100", ov_a, od_a);
    end
  endtask

  task automatic test_lock_k1();
    do_reset();
    beat(4'b1010, 32'h03020100);
    checks++;
    if (al_a !== 1'b1 || off_a !== 2'd1) begin
      failures++;
      $display("FAIL lock_k1 al=%b off=%0d exp 1 1", al_a, off_a);
    end
    beat(4'b1010, 32'h07060504);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'h04030201) begin
      failures++;
      $display("FAIL data_k1a ov=%b od=%h exp 1 04030201", ov_a, od_a);
    end
    beat(4'b1010, 32'h0B0A0908);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'h08070605) begin
      failures++;
      $display("FAIL data_k1b ov=%b od=%h exp 1 08070605", ov_a, od_a);
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    beat(4'b0101, 32'h0);
    for (int i = 0; i < 3; i++) beat(4'b1010, 32'h11);
    checks++;
    if (al_a !== 1'b1) begin
      failures++;
      $display("FAIL hyst_3miss al=%b exp 1", al_a);
    end
    beat(4'b0101, 32'h22);
    checks++;
    if (al_a !== 1'b1 || off_a !== 2'd0 || rc_a !== 8'd0) begin
      failures++;
      $display("FAIL hyst_clear al=%b off=%0d rc=%0d exp 1 0 0",
               al_a, off_a, rc_a);
    end
    for (int i = 0; i < 3; i++) beat(4'b1010, 32'h33);
    checks++;
    if (al_a !== 1'b1 || rc_a !== 8'd0) begin
      failures++;
      $display("FAIL hyst_pre al=%b rc=%0d exp 1 0", al_a, rc_a);
    end
    beat(4'b1010, 32'h44);
    checks++;
    if (al_a !== 1'b0 || rc_a !== 8'd1 || off_a !== 2'd0) begin
      failures++;
      $display("FAIL hyst_drop al=%b rc=%0d off=%0d exp 0 1 0",
               al_a, rc_a, off_a);
    end
    beat(4'b1010, 32'h55);
    checks++;
    if (al_a !== 1'b1 || off_a !== 2'd1 || ov_a !== 1'b0 ||
        rc_a !== 8'd1) begin
      failures++;
      $display("FAIL relock al=%b off=%0d ov=%b rc=%0d exp 1 1 0 1",
               al_a, off_a, ov_a, rc_a);
    end
  endtask

  task automatic test_bad_pattern();
    do_reset();
    beat(4'b0011, 32'hAA);
    beat(4'b0000, 32'hBB);
    beat(4'b0100, 32'hCC);
    checks++;
    if (al_a !== 1'b0 || ov_a !== 1'b0 || off_a !== 2'd0) begin
      failures++;
      $display("FAIL bad_pat al=%b ov=%b off=%0d exp 0 0 0",
               al_a, ov_a, off_a);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    beat(4'b1010, 32'h03020100);
    beat(4'b1010, 32'h07060504);
    gap(4'b0101, 32'hDEADBEEF);
    checks++;
    if (ov_a !== 1'b0 || od_a !== 32'h04030201) begin
      failures++;
      $display("FAIL gap1 ov=%b od=%h exp 0 04030201", ov_a, od_a);
    end
    beat(4'b1010, 32'h0B0A0908);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'h08070605) begin
      failures++;
      $display("FAIL gap_beat ov=%b od=%h exp 1 08070605", ov_a, od_a);
    end
    gap(4'b0101, 32'hCAFEF00D);
    gap(4'b0101, 32'h12345678);
    gap(4'b0101, 32'h9ABCDEF0);
    gap(4'b0101, 32'h0F0F0F0F);
    checks++;
    if (ov_a !== 1'b0 || od_a !== 32'h08070605 || al_a !== 1'b1 ||
        off_a !== 2'd1 || rc_a !== 8'd0) begin
      failures++;
      $display("FAIL gap2 ov=%b od=%h al=%b off=%0d rc=%0d",
               ov_a, od_a, al_a, off_a, rc_a);
    end
    beat(4'b1010, 32'h0F0E0D0C);
    checks++;
    if (ov_a !== 1'b1 || od_a !== 32'h0C0B0A09) begin
      failures++;
      $display("FAIL gap_hold ov=%b od=%h exp 1 0C0B0A09", ov_a, od_a);
    end
  endtask

  task automatic test_multi_lane();
    logic [255:0] exp_d;
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int o = 0; o < 8; o++)
        d_b[(l*8+o)*8 +: 8] = 8'(l*16 + o);
    v_b = 1'b1; sof_b = 8'b0100_0100;
    tick();
    checks++;
    if (al_b !== 1'b1 || off_b !== 3'd2) begin
      failures++;
      $display("FAIL ml_lock al=%b off=%0d exp 1 2", al_b, off_b);
    end
    for (int l = 0; l < 4; l++)
      for (int o = 0; o < 8; o++)
        d_b[(l*8+o)*8 +: 8] = 8'(l*16 + 8 + o);
    tick();
    for (int l = 0; l < 4; l++)
      for (int o = 0; o < 8; o++)
        exp_d[(l*8+o)*8 +: 8] = 8'(l*16 + 2 + o);
    checks++;
    if (ov_b !== 1'b1 || od_b !== exp_d) begin
      failures++;
      $display("FAIL ml_data ov=%b od=%h exp %h", ov_b, od_b, exp_d);
    end
    v_b = 1'b0;
    tick();
    checks++;
    if (ov_b !== 1'b0 || od_b !== exp_d) begin
      failures++;
      $display("FAIL ml_gap ov=%b od=%h exp 0 %h", ov_b, od_b, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_lock_k0();
    test_lock_k1();
    test_hysteresis();
    test_bad_pattern();
    test_gaps();
    test_multi_lane();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
